// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared constants for the register file. The module parameters
//               of reg_file take their default values from this package.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    // Default width of each stored word, in bits
    localparam int c_DEFAULT_DATA_WIDTH = 8;

    // Default address width; the file holds 2**ADDR_WIDTH words
    localparam int c_DEFAULT_ADDR_WIDTH = 3;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : Register file with one synchronous write port and one
//               combinational read port. An asynchronous active-low reset
//               clears every word. There is no write-to-read bypass, so a
//               write becomes visible on r_data only after its clock edge.
// Revision    : 1.0 - initial release
//
// Ports
//   clk      in   1           rising-edge clock for all state updates
//   reset_n  in   1           asynchronous active-low clear of all words
//   wr_en    in   1           write enable, active-high
//   w_addr   in   ADDR_WIDTH  write address
//   w_data   in   DATA_WIDTH  write data
//   r_addr   in   ADDR_WIDTH  read address
//   r_data   out  DATA_WIDTH  word at r_addr, zero-cycle latency
// ============================================================================
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    // Every word sits behind the array-wide asynchronous clear, so this maps
    // to clearable flip-flops rather than a RAM macro.
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    // Reset wins over a simultaneous write because it is tested first and is
    // also in the sensitivity list.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[w_addr] <= w_data;
        end
    end

    // Pure mux on the stored words: old value until the write edge, new value
    // right after it.
    assign r_data = r_mem[r_addr];

endmodule : reg_file
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file
// Description : Self-checking bench for reg_file. Stimulus pushes the expected
//               read value (from an array model of the storage) into a
//               scoreboard queue and signals a sample event; a separate
//               monitor pops and compares against r_data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          reset_n;
    logic          wr_en;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;

    reg_file #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .r_addr  (r_addr),
        .r_data  (r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents of each word, as seen by the outside world
    logic [DW-1:0] model [DEPTH];

    typedef struct {
        string         nm;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    event ev_sample;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // Present an address and queue the value it must read back
    task automatic check_rd(input logic [AW-1:0] a, input string nm);
        exp_t e;
        r_addr = a;
        e.nm   = nm;
        e.addr = a;
        e.data = model[a];
        sb_q.push_back(e);
        -> ev_sample;
        #2;
    endtask

    task automatic sweep(input string nm);
        for (int i = 0; i < DEPTH; i++) check_rd(AW'(i), nm);
    endtask

    // Drive a write at the negedge; the model takes it at the next posedge
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        wr_en  = 1'b1;
        w_addr = a;
        w_data = d;
        @(posedge clk);
        if (reset_n) model[a] = d;
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Monitor: compares r_data with the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(ev_sample);
            #1;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty got=0x%02h", r_data);
            end else begin
                e = sb_q.pop_front();
                if (r_data !== e.data) begin
                    n_fail++;
                    $display("FAIL %s addr=%0d got=0x%02h exp=0x%02h",
                             e.nm, e.addr, r_data, e.data);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic          we;
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        logic [DW-1:0] wd;

        reset_n = 1'b0;
        wr_en   = 1'b0;
        w_addr  = '0;
        w_data  = '0;
        r_addr  = '0;
        clear_model();

        // Reset pulse, then every address reads zero
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        sweep("reset_sweep");

        // Fill with 0xF0+i, then read back in order
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), DW'(8'hF0 + i));
        idle();
        #1;
        sweep("fill_sweep");

        // Write enable low: address 3 must keep 0xF3
        @(negedge clk);
        wr_en  = 1'b0;
        w_addr = 3'd3;
        w_data = 8'hAA;
        @(posedge clk);
        #1;
        check_rd(3'd3, "wr_en_low_hold");

        // Same-cycle read of a word being written: old before edge, new after
        @(negedge clk);
        r_addr = 3'd5;
        wr_en  = 1'b1;
        w_addr = 3'd5;
        w_data = 8'h5A;
        #1;
        check_rd(3'd5, "no_bypass_before_edge");
        @(posedge clk);
        model[5] = 8'h5A;
        #1;
        check_rd(3'd5, "write_after_edge");
        idle();

        // Reset between edges clears at once; a write during reset is lost
        #2;
        reset_n = 1'b0;
        clear_model();
        wr_en  = 1'b1;
        w_addr = 3'd2;
        w_data = 8'h77;
        sweep("async_reset_sweep");
        @(negedge clk);
        wr_en   = 1'b0;
        reset_n = 1'b1;
        #1;
        check_rd(3'd2, "write_during_reset_ignored");

        // First edge after reset release accepts a write
        do_write(3'd4, 8'h3C);
        idle();
        #1;
        check_rd(3'd4, "first_write_after_reset");

        // Back-to-back writes to address 7; neighbour untouched
        do_write(3'd7, 8'h11);
        do_write(3'd7, 8'h22);
        idle();
        #1;
        check_rd(3'd7, "back_to_back_last_wins");
        check_rd(3'd6, "neighbour_unchanged");

        // Randomized writes and reads against the model
        for (int n = 0; n < 200; n++) begin
            we = 1'($urandom_range(0, 1));
            wa = AW'($urandom_range(0, DEPTH - 1));
            wd = DW'($urandom);
            ra = AW'($urandom_range(0, DEPTH - 1));
            @(negedge clk);
            wr_en  = we;
            w_addr = wa;
            w_data = wd;
            #1;
            check_rd(ra, "rand_pre_edge");
            @(posedge clk);
            if (we) model[wa] = wd;
            #1;
            check_rd(ra, "rand_post_edge");
        end
        idle();
        #1;
        sweep("final_sweep");

        #5;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_file
`default_nettype wire

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The module SHALL take parameter DATA_WIDTH, default 8: the width of each stored word in bits.
REQ-002 The module SHALL take parameter ADDR_WIDTH, default 3: the address width, giving 2**ADDR_WIDTH words.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The module SHALL have port wr_en, input, 1 bit: write enable, active-high.
REQ-006 The module SHALL have port w_addr, input, ADDR_WIDTH bits: the write address.
REQ-007 The module SHALL have port w_data, input, DATA_WIDTH bits: the write data.
REQ-008 The module SHALL have port r_addr, input, ADDR_WIDTH bits: the read address.
REQ-009 The module SHALL have port r_data, output, DATA_WIDTH bits: the read data.

Function
REQ-010 The storage SHALL be an array of 2**ADDR_WIDTH words, each DATA_WIDTH bits wide, with no unused or aliased entries.
REQ-011 On a rising clk edge with wr_en=1 and reset_n=1, the word at w_addr SHALL be loaded with w_data; all other words SHALL hold their values.
REQ-012 With wr_en=0, no word SHALL change, regardless of w_addr or w_data.
REQ-013 The read path SHALL be combinational: r_data equals the word at r_addr with zero-cycle latency and no clock dependency.
REQ-014 When a write targets r_addr, r_data SHALL show the old value until the write edge and the new value right after it; there is no write-to-read bypass.
REQ-015 Every address from 0 to 2**ADDR_WIDTH-1 SHALL be valid for both ports; no wrap-around or out-of-range case exists.
REQ-016 Reads and writes to the same or different addresses in the same cycle SHALL be fully independent, with no conflict or stall.
REQ-017 There SHALL be no handshake, status outputs or error reporting.

Reset
REQ-018 When reset_n=0, all words SHALL clear to 0 immediately, without waiting for a clock edge, so r_data reads 0 for any r_addr.
REQ-019 While reset_n=0, writes SHALL be ignored, and reset SHALL take priority over a simultaneous write.
REQ-020 After reset_n rises, the first rising clk edge SHALL accept writes normally.
REQ-021 An assertion of reset mid-operation SHALL discard all stored contents.

Structure
REQ-022 The default width constants (DATA_WIDTH=8, ADDR_WIDTH=3) SHALL live in a shared package, reg_file_pkg, and the module parameters SHALL default from it.
REQ-023 The design SHALL be a single module with no sub-module: one storage array, one sequential write process and one combinational read assignment.
REQ-024 The RTL SHALL be synthesizable as flip-flops with an asynchronous clear (not inferred RAM, because of the array-wide reset).

Verification
REQ-025 The bench SHALL pulse reset_n low, then sweep r_addr 0..7 -> r_data=0x00 at every address.
REQ-026 The bench SHALL write at each negedge with wr_en=1, w_addr=i, w_data=0xF0+i for i=0..7, then set wr_en=0 and sweep r_addr 0..7 -> r_data=0xF0..0xF7 in order.
REQ-027 The bench SHALL set wr_en=0, w_addr=3, w_data=0xAA for one edge -> r_addr=3 still reads 0xF3.
REQ-028 The bench SHALL set r_addr=5 and write 0x5A to address 5 -> r_data reads 0xF5 before the edge and 0x5A after it, same cycle.
REQ-029 The bench SHALL assert reset_n=0 between clock edges after the writes -> r_data=0x00 immediately for all addresses; a write attempted during reset has no effect.
REQ-030 The bench SHALL write 0x11 then 0x22 to address 7 on consecutive edges -> r_data at address 7 reads 0x22, and address 6 is unchanged.
